alu_calc_seq: RTL and testbench



---
 rtl/alu_calc_seq_if.sv | 30 +++
 rtl/alu_calc_seq.sv | 152 +++++++++++++++
 tb/tb_alu_calc_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_calc_seq_if.sv
// Front-panel / ALU bus of the calculator sequencer.
// The slave side is the sequencer; the master side drives entries and the ALU result.
interface alu_calc_seq_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       digit_in;
    logic             digit_valid;
    logic [2:0]       op_in;
    logic             op_valid;
    logic             eq;
    logic             clr;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [2:0]       alu_sel;
    logic [3:0]       alu_result;
    logic [3:0]       display;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] exec_cnt;

    modport slave (
        input  digit_in, digit_valid, op_in, op_valid, eq, clr, alu_result,
        output alu_a, alu_b, alu_sel, display, busy, done, exec_cnt
    );

    modport master (
        output digit_in, digit_valid, op_in, op_valid, eq, clr, alu_result,
        input  alu_a, alu_b, alu_sel, display, busy, done, exec_cnt
    );
endinterface

// File: rtl/alu_calc_seq.sv
// Calculator sequencer: collects operand/opcode entries, drives the 4-bit ALU
// from registers, captures its result and supports chaining, repeat-equals and clear.
//
// state  | meaning
// S_A    | waiting for first operand digit
// S_OP   | operand A held, waiting for opcode (digits overwrite A)
// S_B    | opcode held, waiting for operand B (ops overwrite opcode)
// S_EQ   | operands ready, waiting for execute (digits/ops overwrite B/opcode)
// S_EXEC | single execute cycle, ALU result captured at its end
// S_RES  | result shown; op chains, digit restarts, eq repeats
module alu_calc_seq #(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_calc_seq_if.slave      bus
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_EQ   = 3'd3,
        S_EXEC = 3'd4,
        S_RES  = 3'd5
    } state_t;

    state_t           state_q,   state_d;
    logic [3:0]       reg_a_q,   reg_a_d;
    logic [3:0]       reg_b_q,   reg_b_d;
    logic [2:0]       reg_op_q,  reg_op_d;
    logic [3:0]       acc_q,     acc_d;
    logic [3:0]       display_q, display_d;
    logic             done_q,    done_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_A;
            reg_a_q   <= 4'h0;
            reg_b_q   <= 4'h0;
            reg_op_q  <= 3'b000;
            acc_q     <= 4'h0;
            display_q <= 4'h0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            reg_a_q   <= reg_a_d;
            reg_b_q   <= reg_b_d;
            reg_op_q  <= reg_op_d;
            acc_q     <= acc_d;
            display_q <= display_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

    // Each branch tests strobes in priority order so only the highest one acts.
    always_comb begin
        state_d   = state_q;
        reg_a_d   = reg_a_q;
        reg_b_d   = reg_b_q;
        reg_op_d  = reg_op_q;
        acc_d     = acc_q;
        display_d = display_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;

        if (bus.clr) begin
            state_d   = S_A;
            reg_a_d   = 4'h0;
            reg_b_d   = 4'h0;
            reg_op_d  = 3'b000;
            acc_d     = 4'h0;
            display_d = 4'h0;
        end else begin
            case (state_q)
                S_A: begin
                    if (bus.digit_valid) begin
                        reg_a_d   = bus.digit_in;
                        display_d = bus.digit_in;
                        state_d   = S_OP;
                    end
                end
                S_OP: begin
                    if (bus.op_valid) begin
                        reg_op_d = bus.op_in;
                        state_d  = S_B;
                    end else if (bus.digit_valid) begin
                        reg_a_d   = bus.digit_in;
                        display_d = bus.digit_in;
                    end
                end
                S_B: begin
                    if (bus.op_valid) begin
                        reg_op_d = bus.op_in;
                    end else if (bus.digit_valid) begin
                        reg_b_d   = bus.digit_in;
                        display_d = bus.digit_in;
                        state_d   = S_EQ;
                    end
                end
                S_EQ: begin
                    if (bus.eq) begin
                        state_d = S_EXEC;
                    end else if (bus.op_valid) begin
                        reg_op_d = bus.op_in;
                    end else if (bus.digit_valid) begin
                        reg_b_d   = bus.digit_in;
                        display_d = bus.digit_in;
                    end
                end
                S_EXEC: begin
                    acc_d     = bus.alu_result;
                    display_d = bus.alu_result;
                    done_d    = 1'b1;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    state_d = S_RES;
                end
                S_RES: begin
                    if (bus.eq) begin
                        reg_a_d = acc_q;
                        state_d = S_EXEC;
                    end else if (bus.op_valid) begin
                        reg_a_d  = acc_q;
                        reg_op_d = bus.op_in;
                        state_d  = S_B;
                    end else if (bus.digit_valid) begin
                        reg_a_d   = bus.digit_in;
                        display_d = bus.digit_in;
                        state_d   = S_OP;
                    end
                end
                default: begin
                    state_d = S_A;
                end
            endcase
        end
    end

    assign bus.alu_a    = reg_a_q;
    assign bus.alu_b    = reg_b_q;
    assign bus.alu_sel  = reg_op_q;
    assign bus.display  = display_q;
    assign bus.busy     = (state_q == S_EXEC);
    assign bus.done     = done_q;
    assign bus.exec_cnt = cnt_q;

endmodule

// File: tb/tb_alu_calc_seq.sv
// Bench for alu_calc_seq: directed calculator sequences plus random strobes,
// all checked each cycle against a behavioural calculator model.
module tb_alu_calc_seq;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int P_A    = 0;
    localparam int P_OP   = 1;
    localparam int P_B    = 2;
    localparam int P_EQ   = 3;
    localparam int P_EXEC = 4;
    localparam int P_RES  = 5;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    alu_calc_seq_if #(.CNT_W(CNT_W)) ifc ();

    alu_calc_seq #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] alu_ref(input logic [2:0] sel, input logic [3:0] a, input logic [3:0] b);
        int ia = int'(a);
        int ib = int'(b);
        int r;
        case (sel)
            3'd0:    r = (ia + ib) % 16;
            3'd1:    r = (ia - ib + 16) % 16;
            3'd2:    r = ia & ib;
            3'd3:    r = ia | ib;
            3'd4:    r = ia ^ ib;
            3'd5:    r = 15 - ia;
            3'd6:    r = ib;
            default: r = 0;
        endcase
        return r[3:0];
    endfunction

    // Environment ALU feeding the sequencer.
    always_comb ifc.alu_result = alu_ref(ifc.alu_sel, ifc.alu_a, ifc.alu_b);

    int         m_phase;
    logic [3:0] m_a, m_b, m_acc, m_disp;
    logic [2:0] m_op;
    logic       m_done;
    int         m_cnt;

    task automatic model_reset(input bit keep_cnt);
        m_phase = P_A;
        m_a = 0; m_b = 0; m_op = 0; m_acc = 0; m_disp = 0; m_done = 0;
        if (!keep_cnt) m_cnt = 0;
    endtask

    task automatic model_step(input bit c, input bit e, input bit ov, input logic [2:0] o,
                              input bit dv, input logic [3:0] d);
        bit finished = 0;
        if (c) begin
            model_reset(1);
        end else if (m_phase == P_EXEC) begin
            m_acc  = alu_ref(m_op, m_a, m_b);
            m_disp = m_acc;
            if (m_cnt < CNT_MAX) m_cnt++;
            finished = 1;
            m_phase = P_RES;
        end else if (e && (m_phase == P_EQ || m_phase == P_RES)) begin
            if (m_phase == P_RES) m_a = m_acc;
            m_phase = P_EXEC;
        end else if (ov && m_phase != P_A) begin
            if (m_phase == P_RES) m_a = m_acc;
            m_op = o;
            if (m_phase == P_OP || m_phase == P_RES) m_phase = P_B;
        end else if (dv) begin
            m_disp = d;
            if (m_phase == P_B || m_phase == P_EQ) begin
                m_b = d;
                m_phase = P_EQ;
            end else begin
                m_a = d;
                m_phase = P_OP;
            end
        end
        m_done = finished;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("alu_a",    32'(ifc.alu_a),    32'(m_a));
        check_val("alu_b",    32'(ifc.alu_b),    32'(m_b));
        check_val("alu_sel",  32'(ifc.alu_sel),  32'(m_op));
        check_val("display",  32'(ifc.display),  32'(m_disp));
        check_val("busy",     32'(ifc.busy),     32'(m_phase == P_EXEC));
        check_val("done",     32'(ifc.done),     32'(m_done));
        check_val("exec_cnt", 32'(ifc.exec_cnt), 32'(m_cnt));
    endtask

    // Called at a falling edge; applies strobes for one rising edge, then checks.
    task automatic cycle(input bit c, input bit e, input bit ov, input logic [2:0] o,
                         input bit dv, input logic [3:0] d);
        ifc.clr = c; ifc.eq = e; ifc.op_valid = ov; ifc.op_in = o;
        ifc.digit_valid = dv; ifc.digit_in = d;
        @(posedge clk);
        model_step(c, e, ov, o, dv, d);
        @(negedge clk);
        ifc.clr = 0; ifc.eq = 0; ifc.op_valid = 0; ifc.digit_valid = 0;
        check_all();
    endtask

    task automatic idle();     cycle(0, 0, 0, 3'd0, 0, 4'd0); endtask
    task automatic clr_in();   cycle(1, 0, 0, 3'd0, 0, 4'd0); endtask
    task automatic eq_in();    cycle(0, 1, 0, 3'd0, 0, 4'd0); endtask
    task automatic op(input logic [2:0] o);    cycle(0, 0, 1, o, 0, 4'd0); endtask
    task automatic dig(input logic [3:0] d);   cycle(0, 0, 0, 3'd0, 1, d); endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 0;
        ifc.clr = 0; ifc.eq = 0; ifc.op_valid = 0; ifc.op_in = 0;
        ifc.digit_valid = 0; ifc.digit_in = 0;
        model_reset(0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        check_all();

        // 3 + 5
        dig(4'd3); op(3'd0); dig(4'd5); eq_in();
        check_val("add_busy", 32'(ifc.busy), 32'd1);
        idle();
        check_val("add_disp", 32'(ifc.display), 32'd8);
        check_val("add_done", 32'(ifc.done), 32'd1);
        check_val("add_cnt",  32'(ifc.exec_cnt), 32'd1);
        check_val("add_sel",  32'(ifc.alu_sel), 32'd0);
        idle();
        check_val("done_pulse", 32'(ifc.done), 32'd0);

        // 2 - 5 then chain + 4
        clr_in();
        dig(4'd2); op(3'd1); dig(4'd5); eq_in(); idle();
        check_val("sub_disp", 32'(ifc.display), 32'hD);
        op(3'd0); dig(4'd4); eq_in();
        check_val("chain_a", 32'(ifc.alu_a), 32'hD);
        idle();
        check_val("chain_disp", 32'(ifc.display), 32'd1);

        // 7 ^ 2 with repeat-equals
        clr_in();
        dig(4'd7); op(3'd4); dig(4'd2); eq_in(); idle();
        check_val("xor_disp", 32'(ifc.display), 32'd5);
        eq_in(); idle();
        check_val("rep1_disp", 32'(ifc.display), 32'd7);
        eq_in(); idle();
        check_val("rep2_disp", 32'(ifc.display), 32'd5);
        check_val("rep_cnt", 32'(ifc.exec_cnt), 32'd6);

        // eq with simultaneous digit executes only
        clr_in();
        dig(4'd1); op(3'd0); dig(4'd5);
        cycle(0, 1, 0, 3'd0, 1, 4'd9);
        check_val("eqdig_busy", 32'(ifc.busy), 32'd1);
        check_val("eqdig_b", 32'(ifc.alu_b), 32'd5);
        idle();
        check_val("eqdig_disp", 32'(ifc.display), 32'd6);

        // clear during execute: no result, no done
        clr_in();
        dig(4'd1); op(3'd0); dig(4'd2); eq_in();
        clr_in();
        check_val("clrx_disp", 32'(ifc.display), 32'd0);
        check_val("clrx_done", 32'(ifc.done), 32'd0);
        idle();
        check_val("clrx_done2", 32'(ifc.done), 32'd0);
        check_val("clrx_cnt", 32'(ifc.exec_cnt), 32'd7);

        // eq ignored in S_A / S_OP / S_B
        eq_in();
        check_val("eqA_busy", 32'(ifc.busy), 32'd0);
        dig(4'd3); eq_in();
        check_val("eqOP_busy", 32'(ifc.busy), 32'd0);
        op(3'd3); eq_in();
        check_val("eqB_busy", 32'(ifc.busy), 32'd0);

        // asynchronous reset while in S_B
        #1 rst_n = 0;
        #1;
        model_reset(0);
        check_all();
        @(negedge clk);
        rst_n = 1;
        check_all();

        // opcode 111 gives zero
        dig(4'd4); op(3'd7); dig(4'd9); eq_in(); idle();
        check_val("zero_disp", 32'(ifc.display), 32'd0);

        // random strobes against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
        end

        // counter saturation
        clr_in();
        dig(4'd1); op(3'd0); dig(4'd1); eq_in(); idle();
        for (int i = 0; i < 300 && m_cnt < CNT_MAX; i++) begin
            eq_in(); idle();
        end
        check_val("sat_reach", 32'(ifc.exec_cnt), 32'd255);
        eq_in(); idle();
        check_val("sat_hold", 32'(ifc.exec_cnt), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
